// File: rtl/arb_pkg.sv
// Shared types and helpers for the grant-lock stage and its one-hot encoder.
package arb_pkg;

  localparam int DEF_NUM_PORTS = 8;
  localparam int MAX_PORTS     = 64;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Callers zero-extend their vector to MAX_PORTS bits.
  function automatic logic is_onehot(input logic [MAX_PORTS-1:0] v);
    return (v != '0) && ((v & (v - 64'd1)) == '0);
  endfunction

endpackage

// File: rtl/arb_onehot_enc.sv
// One-hot to binary encoder; an all-zero input encodes to 0.
module arb_onehot_enc #(
  parameter int NUM_PORTS = 8
) (
  input  logic [NUM_PORTS-1:0]         onehot_i,
  output logic [$clog2(NUM_PORTS)-1:0] idx_o
);

  localparam int IW = $clog2(NUM_PORTS);

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (onehot_i[i]) idx_o = idx_o | IW'(i);
    end
  end

endmodule

// File: rtl/arb_gnt_lock.sv
// Registered grant lock behind a combinational fixed-priority arbiter, with a
// hold timeout that masks the expired owner from the next arbitration round.
// Handshake: there is no valid/ready pair; a grant is live exactly while
// gnt_valid_o is high, and release_i is a single-cycle pulse honoured only in BUSY.
module arb_gnt_lock
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int MAX_HOLD  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_PORTS-1:0]         req_i,
  output logic [NUM_PORTS-1:0]         arb_req_o,
  input  logic [NUM_PORTS-1:0]         arb_gnt_i,
  input  logic                         release_i,
  output logic [NUM_PORTS-1:0]         gnt_o,
  output logic [$clog2(NUM_PORTS)-1:0] gnt_idx_o,
  output logic                         gnt_valid_o,
  output logic                         err_o,
  output logic                         dbg_state_o
);

  localparam int CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  state_e                         state;
  logic [NUM_PORTS-1:0]           mask;
  logic [NUM_PORTS-1:0]           masked_req;
  logic [NUM_PORTS-1:0]           cand;
  logic [$clog2(NUM_PORTS)-1:0]   cand_idx;
  logic [CW-1:0]                  hold_cnt;
  logic                           owner_req;
  logic                           timeout;

  // A lone requester bypasses the mask so it is never starved by itself.
  assign masked_req = req_i & ~mask;
  assign arb_req_o  = (|masked_req) ? masked_req : req_i;
  assign cand       = arb_gnt_i & arb_req_o;
  assign owner_req  = |(req_i & gnt_o);
  assign timeout    = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign dbg_state_o = (state == BUSY);

  arb_onehot_enc #(.NUM_PORTS(NUM_PORTS)) u_enc (
    .onehot_i (cand),
    .idx_o    (cand_idx)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      gnt_o       <= '0;
      gnt_idx_o   <= '0;
      gnt_valid_o <= 1'b0;
      err_o       <= 1'b0;
      mask        <= '0;
      hold_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|cand) begin
            if (is_onehot(MAX_PORTS'(cand))) begin
              state       <= BUSY;
              gnt_o       <= cand;
              gnt_idx_o   <= cand_idx;
              gnt_valid_o <= 1'b1;
              mask        <= '0;
              hold_cnt    <= '0;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (hold_cnt != '1) hold_cnt <= hold_cnt + CW'(1);
          if (timeout || !owner_req || release_i) begin
            state       <= IDLE;
            gnt_o       <= '0;
            gnt_idx_o   <= '0;
            gnt_valid_o <= 1'b0;
            // Timeout wins over a coincident drop/release for the mask.
            mask        <= timeout ? gnt_o : '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
